// File: rtl/uart_rx_param_if.sv
// Receive-side drain bus of the parametrised UART receiver: FIFO head
// fields plus the valid/ready handshake.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output rx_data, rx_parity_err, rx_frame_err, rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_parity_err, rx_frame_err, rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample majority vote
// per bit, false-start rejection, parity/framing flags and a small receive
// FIFO drained over a valid/ready interface.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 432,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rxd,
  uart_rx_param_if.master rx,
  output logic            overflow,
  output logic            busy
);
  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] C_S0   = CW'(H - 1);
  localparam logic [CW-1:0] C_S1   = CW'(H);
  localparam logic [CW-1:0] C_DEC  = CW'(H + 1);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, PUSH} state_t;

  typedef struct packed {
    logic                 fe;
    logic                 pe;
    logic [DATA_BITS-1:0] data;
  } entry_t;

  state_t               state, state_nx;
  logic                 s1, rxd_s, rxd_q;
  logic [CW-1:0]        cnt;
  logic [3:0]           bidx;
  logic                 smp_a, smp_b, vote, dec, end_bit;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err, frm_err;
  logic                 push, pop, wr_en, empty, full;
  logic [AW:0]          wr_ptr, rd_ptr;
  entry_t               mem [FIFO_DEPTH];
  entry_t               head;

  // Two-flop synchroniser plus one history flop for falling-edge detection;
  // idle-high reset so leaving reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst)
    if (rst) {s1, rxd_s, rxd_q} <= 3'b111;
    else     {s1, rxd_s, rxd_q} <= {rxd, s1, rxd_s};

  assign dec     = (cnt == C_DEC);
  assign end_bit = (cnt == C_LAST);
  assign vote    = (smp_a & smp_b) | (smp_a & rxd_s) | (smp_b & rxd_s);

  // FSM state register.
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;

  // Next-state logic; the last stop bit hands off at its vote, not its end,
  // so a back-to-back start edge is never missed.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (rxd_q && !rxd_s) state_nx = START;
      START: if (dec && vote) state_nx = IDLE;
             else if (end_bit) state_nx = DATA;
      DATA:  if (end_bit && bidx == LAST_DATA) state_nx = (PARITY != 0) ? PAR : STOP;
      PAR:   if (end_bit) state_nx = STOP;
      STOP:  if (dec && bidx == LAST_STOP) state_nx = PUSH;
      PUSH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state != IDLE);
    push = (state == PUSH);
  end

  // Bit timing, majority samples, shift register and error flags.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt     <= '0;
      bidx    <= '0;
      smp_a   <= 1'b0;
      smp_b   <= 1'b0;
      shreg   <= '0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      if (state_nx != state || end_bit) cnt <= '0;
      else                              cnt <= cnt + 1'b1;
      if (state_nx != state) bidx <= '0;
      else if (end_bit)      bidx <= bidx + 1'b1;
      if (cnt == C_S0) smp_a <= rxd_s;
      if (cnt == C_S1) smp_b <= rxd_s;
      if (state == IDLE) begin
        shreg   <= '0;
        par_err <= 1'b0;
        frm_err <= 1'b0;
      end else if (dec) begin
        case (state)
          DATA: shreg   <= {vote, shreg[DATA_BITS-1:1]};
          PAR:  par_err <= (^shreg) ^ vote ^ (PARITY == 2);
          STOP: if (!vote) frm_err <= 1'b1;
          default: ;
        endcase
      end
    end

  // FIFO control: a pop frees the slot the same cycle, so full+push+pop is
  // accepted; only full+push without pop drops the frame.
  always_comb begin
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop      = rx.rx_ready && !empty;
    wr_en    = push && (!full || pop);
    overflow = push && full && !pop;
  end

  // FIFO pointers with an extra wrap bit.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end

  // FIFO storage; contents are don't-care while empty since the head is gated.
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= '{fe: frm_err, pe: par_err, data: shreg};

  assign head             = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign rx.rx_data       = head.data;
  assign rx.rx_parity_err = head.pe;
  assign rx.rx_frame_err  = head.fe;
  assign rx.rx_valid      = !empty;
endmodule
